output_parallel_to_serial: RTL and testbench
============================================

# output_parallel_to_serial

Frame-based parallel-to-serial converter at the readout output stage. It captures a WIDTH_INPUT-bit word from `data_in` and shifts it out MSB-first on the single-bit `data_out`, one bit per clock. It reloads automatically every WIDTH_INPUT cycles, so the serial stream has no gaps. It has no handshake; upstream must present the word at the load edge.

## Interface
- WIDTH_INPUT, default 128: parallel word width and frame length in clocks; must be ≥ 2.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- data_in  input  WIDTH_INPUT  parallel word; sampled only on load edges.
- data_out  input/output: output  1  registered serial bit, MSB of each frame first.

## Operation
- Internal state:
  - shift register `sr` [WIDTH_INPUT-1:0].
  - down-counter `cnt`, width $clog2(WIDTH_INPUT).
  - registered `data_out`.
- Reset (RST_N low, asynchronous): `sr`=0, `cnt`=0, `data_out`=0. These values hold while RST_N stays low.
- Load edge (rising edge with `cnt`==0):
  - `data_out` <= data_in[WIDTH_INPUT-1].
  - `sr` <= {data_in[WIDTH_INPUT-2:0], 1'b0}.
  - `cnt` <= WIDTH_INPUT-1.
- Shift edge (rising edge with `cnt`≠0):
  - `data_out` <= sr[WIDTH_INPUT-1].
  - `sr` <= sr << 1.
  - `cnt` <= `cnt`-1.
- Frame period is exactly WIDTH_INPUT clocks. Load edges fall at 0, W, 2W, … counting from the first edge after reset release.
- `data_in` is ignored on all edges except load edges. A change mid-frame does not affect the current frame.
- An all-zero word produces a constant-0 frame. No special idle state exists; the converter free-runs.

## Timing
- First rising edge after RST_N deasserts is a load edge.
- Bit k of a frame (k=0 is the MSB, data_in[W-1-k]) is valid on `data_out` from edge L+k until edge L+k+1, where L is the load edge.
- Latency from `data_in` sampling to first serial bit: 0 cycles after the load edge (registered output).
- Last bit (LSB) of frame n is followed directly by the MSB of frame n+1, with no idle cycle.
- Reset asserted mid-frame:
  - `data_out` drops to 0 immediately (asynchronously) and the frame is abandoned.
  - After release, the next edge loads a fresh word.
- Counter wrap: `cnt` goes W-1 → 0 without overflow. For non-power-of-two W, `cnt` never exceeds W-1.

## Structure
- No shared package required. Counter width is a local constant derived from WIDTH_INPUT ($clog2).
- Single flat module with two processes:
  - one asynchronous-reset register block;
  - one combinational next-state/load-select block.
- No sub-module is warranted.

## Test plan
- Reset hold: RST_N=0 for 5 cycles with data_in=all-ones → `data_out`=0 throughout.
- Basic frame, W=128:
  - Stimulus: release reset and drive data_in=128'hA5A5…A5 for exactly one clock (the load edge), then 0.
  - Required: `data_out` follows 1,0,1,0,0,1,0,1 repeated 16 times over 128 cycles.
  - Required: the next frame then carries 0 for 128 cycles.
- Mid-frame input change: load 128'hFFFF…F, then drive data_in=0 at cycle 10 → all 128 bits are 1. The following frame loads the current data_in.
- Back-to-back frames:
  - Stimulus: data_in held at 128'h8000…0001.
  - Required pattern per 128-cycle frame: 1, then 126 zeros, then 1.
  - Required: the MSB 1 of the next frame follows the LSB 1 immediately, with no gap.
- Reset mid-frame: assert RST_N low at cycle 40 of a frame → `data_out`=0 within the same cycle. After release, the first edge reloads and the new MSB appears.
- Non-power-of-two width: W=5, data_in=5'b10110 held → `data_out` repeats 1,0,1,1,0 with period 5.

Source files
------------

// File: rtl/output_parallel_to_serial_pkg.sv
// rtl/output_parallel_to_serial_pkg.sv - shared types and sizing helper for the parallel-to-serial output stage
package output_parallel_to_serial_pkg;

  typedef enum logic {
    EDGE_SHIFT = 1'b0,
    EDGE_LOAD  = 1'b1
  } edge_kind_t;

  // Counter width for a frame of `width` clocks; never below one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/output_parallel_to_serial.sv
// rtl/output_parallel_to_serial.sv - free-running MSB-first parallel-to-serial converter, reload every WIDTH_INPUT clocks
module output_parallel_to_serial
  import output_parallel_to_serial_pkg::*;
#(
  parameter int WIDTH_INPUT = 128
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [WIDTH_INPUT-1:0] data_in,
  output logic                   data_out
);

  localparam int CW = cnt_width(WIDTH_INPUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH_INPUT - 1);

  logic [WIDTH_INPUT-1:0] sr, sr_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   data_next;
  edge_kind_t             edge_kind;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sr       <= '0;
      cnt      <= '0;
      data_out <= 1'b0;
    end else begin
      sr       <= sr_next;
      cnt      <= cnt_next;
      data_out <= data_next;
    end
  end

  // The MSB goes straight to the output on a load, so sr only holds the remaining bits.
  always_comb begin
    edge_kind = (cnt == '0) ? EDGE_LOAD : EDGE_SHIFT;
    data_next = sr[WIDTH_INPUT-1];
    sr_next   = sr << 1;
    cnt_next  = cnt - 1'b1;
    if (edge_kind == EDGE_LOAD) begin
      data_next = data_in[WIDTH_INPUT-1];
      sr_next   = {data_in[WIDTH_INPUT-2:0], 1'b0};
      cnt_next  = CNT_LAST;
    end
  end

endmodule

// File: tb/tb_output_parallel_to_serial.sv
// tb/tb_output_parallel_to_serial.sv - self-checking bench for output_parallel_to_serial at W=128 and W=5
module tb_output_parallel_to_serial;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data_in = '0;
  logic [4:0]   data_in5 = '0;
  logic         data_out;
  logic         data_out5;

  int checks = 0;
  int errors = 0;

  int           pos = 0;
  int           pos5 = 0;
  logic [127:0] word = '0;
  logic [4:0]   word5 = '0;
  logic         exp_bit;
  logic         exp_bit5;

  always #5 clk = ~clk;

  output_parallel_to_serial #(.WIDTH_INPUT(128)) dut (
    .CLK(clk), .RST_N(rst_n), .data_in(data_in), .data_out(data_out)
  );

  output_parallel_to_serial #(.WIDTH_INPUT(5)) dut5 (
    .CLK(clk), .RST_N(rst_n), .data_in(data_in5), .data_out(data_out5)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Frame model: bit k of a frame is word[W-1-k], word captured when k==0.
  task automatic step(input string tag, input logic [127:0] din, input logic [4:0] din5);
    data_in  = din;
    data_in5 = din5;
    if (!rst_n) begin
      pos = 0; pos5 = 0; exp_bit = 1'b0; exp_bit5 = 1'b0;
    end else begin
      if (pos % 128 == 0) word = din;
      exp_bit = word[127 - (pos % 128)];
      pos++;
      if (pos5 % 5 == 0) word5 = din5;
      exp_bit5 = word5[4 - (pos5 % 5)];
      pos5++;
    end
    @(posedge clk);
    #1;
    check({tag, "_w128"}, data_out, exp_bit);
    check({tag, "_w5"}, data_out5, exp_bit5);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] a5, msb_lsb;
    a5      = {16{8'hA5}};
    msb_lsb = {1'b1, 126'b0, 1'b1};

    @(negedge clk);
    for (int i = 0; i < 5; i++) step("reset_hold", '1, 5'b11111);

    rst_n = 1'b1;
    step("a5_frame", a5, 5'b10110);
    for (int i = 0; i < 127; i++) step("a5_frame", '0, 5'b10110);
    for (int i = 0; i < 128; i++) step("zero_frame", '0, 5'b10110);

    for (int i = 0; i < 10; i++) step("midframe_ones", '1, 5'b10110);
    for (int i = 10; i < 128; i++) step("midframe_ones", '0, 5'b10110);
    for (int i = 0; i < 128; i++) step("midframe_next", '0, 5'b10110);

    for (int i = 0; i < 384; i++) step("back_to_back", msb_lsb, 5'b10110);

    for (int i = 0; i < 512; i++) step("random", rnd128(), 5'b10110);

    for (int i = 0; i < 40; i++) step("pre_reset", '1, 5'b10110);
    #2;
    check("before_async_reset", data_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_w128", data_out, 1'b0);
    check("async_reset_w5", data_out5, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step("reset_held", '1, 5'b11111);

    rst_n = 1'b1;
    step("reload", rnd128(), 5'b10110);
    for (int i = 0; i < 255; i++) step("after_reset", rnd128(), 5'b10110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
